cam_capture_rgb332: RTL and testbench
=====================================

// Module: cam_capture_rgb332
// PURPOSE
//  Parametrised camera front end. Assembles the OV7670 two-byte-per-pixel stream into 8-bit RGB332 pixels.
//  Generates the frame-buffer write address and write strobe for the M9K dual-port RAM; runs on the camera PCLK.
//  Adds selectable input format, frame/line sync tracking, cropping, single-frame arming and frame/line status.
// PARAMETERS
//  WIDTH   176  active pixels per line written to memory
//  HEIGHT  144  active lines per frame written to memory
//  ADDR_W  15   write-address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
// PORTS
//  CLK          in   1       camera PCLK; all logic on rising edge
//  RESET        in   1       asynchronous, active-high reset
//  VSYNC        in   1       high = vertical blanking
//  HREF         in   1       high = valid line bytes on D
//  D            in   8       camera data byte
//  MODE         in   2       0 RGB565, 1 RGB444 (xR/GB), 2 YUV422 gray, 3 raw byte0
//  CAPTURE_EN   in   1       arm capture; sampled at frame start
//  PIXEL_OUT    out  8       RGB332 pixel to RAM input_data
//  W_ADDR       out  ADDR_W  RAM write address = Y*WIDTH + X
//  W_EN         out  1       one-cycle write strobe
//  FRAME_DONE   out  1       one-cycle pulse at end of a captured frame
//  FRAME_COUNT  out  8       captured frames, wraps 255->0
//  LINE_ERR     out  1       one-cycle pulse: line ended with pixel count != WIDTH
// BEHAVIOUR
//  Reset: all outputs 0; state S_SYNC; X=Y=0; byte phase=0; latched mode=0, armed=0.
//  FSM: S_SYNC -(VSYNC=1)-> S_VBLANK -(VSYNC=0)-> S_FRAME -(HREF=1)-> S_LINE -(HREF=0)-> S_FRAME; VSYNC=1 in S_FRAME/S_LINE -> S_VBLANK.
//   Frames are never captured starting mid-frame after reset.
//  Frame start (S_VBLANK->S_FRAME): latch MODE and CAPTURE_EN. Mid-frame changes to either have no effect.
//  S_LINE: phase 0 stores D as b0; phase 1 forms pixel from b0 and D=b1.
//   One cycle later: PIXEL_OUT/W_ADDR update and W_EN=1, provided armed && X<WIDTH && Y<HEIGHT; X increments every pixel.
//  Pixel formats:
//   m0 {b0[7:5],b0[2:0],b1[4:3]}
//   m1 {b0[3:1],b1[7:5],b1[3:2]}
//   m2 {b0[7:5],b0[7:5],b0[7:6]}
//   m3 b0
//  Line end (HREF fall): dangling odd byte discarded, phase=0, X=0; Y increments if line had >=1 pixel; LINE_ERR pulses if X!=WIDTH.
//   Pixels beyond WIDTH and lines beyond HEIGHT are dropped (no W_EN), never wrapped.
//  Frame end (VSYNC rise from S_FRAME/S_LINE): Y=0, X=0.
//   If armed: FRAME_DONE pulses and FRAME_COUNT increments, both in the cycle after VSYNC is sampled high.
//   Unarmed frames: no W_EN, no FRAME_DONE, no count.
//  HREF and VSYNC rising in the same cycle: VSYNC wins.
//  W_ADDR computed from registered X,Y with ADDR_W-bit arithmetic; W_ADDR and PIXEL_OUT hold their values between strobes.
//  Async RESET mid-line: immediate clear to reset values; any partial pixel is lost.
// TESTING
//  1 Reset asserted mid-line, HREF high -> no W_EN until a full VSYNC high->low is seen; all outputs 0 during reset.
//  2 MODE=0, b0=0xF8, b1=0x1F as first pixel -> PIXEL_OUT=0xE3, W_ADDR=0, single W_EN one cycle after b1.
//  3 Full 176x144 frame, CAPTURE_EN=1 -> 25344 W_EN pulses, last W_ADDR=25343, one FRAME_DONE, FRAME_COUNT 0->1.
//  4 Line of 180 pixels -> 176 writes, LINE_ERR=1.
//    Following line of 170 pixels -> writes at 176..345, LINE_ERR=1.
//  5 Line of 353 bytes -> 176 pixels written, trailing byte ignored, next line starts at phase 0.
//  6 CAPTURE_EN=0 at frame start, raised mid-frame -> no writes, no FRAME_DONE.
//    MODE 0->2 mid-frame -> format unchanged until the next frame.

Source files
------------

// File: rtl/cam_capture_rgb332.sv
// Camera capture front end: turns the OV7670 two-bytes-per-pixel stream into
// RGB332 pixels and drives the frame-buffer RAM write port. Runs on PCLK.
//
// Ports
//   CLK          camera PCLK, rising edge
//   RESET        asynchronous active-high reset
//   VSYNC        high = vertical blanking
//   HREF         high = valid line bytes on D
//   D[7:0]       camera data byte
//   MODE[1:0]    0 RGB565, 1 RGB444, 2 YUV422 gray, 3 raw byte0
//   CAPTURE_EN   arm capture, sampled at frame start
//   PIXEL_OUT    RGB332 pixel for the RAM data input
//   W_ADDR       RAM write address, Y*WIDTH + X
//   W_EN         one-cycle write strobe
//   FRAME_DONE   one-cycle pulse at the end of a captured frame
//   FRAME_COUNT  captured frame counter, wraps
//   LINE_ERR     one-cycle pulse when a line ends with a pixel count != WIDTH
module cam_capture_rgb332 #(
  parameter int unsigned WIDTH  = 176,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  input  logic [1:0]        MODE,
  input  logic              CAPTURE_EN,
  output logic [7:0]        PIXEL_OUT,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_COUNT,
  output logic              LINE_ERR
);

  // One spare bit so the counters can run past the active area and saturate.
  localparam int unsigned XW = $clog2(WIDTH + 1) + 1;
  localparam int unsigned YW = $clog2(HEIGHT + 1) + 1;

  typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_FRAME, S_LINE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_frame_start;
  logic               w_frame_end;
  logic               w_line_end;
  logic               w_byte;

  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic               r_phase;
  logic [7:0]         r_b0;
  logic [1:0]         r_mode;
  logic               r_armed;
  logic [7:0]         r_pixel;
  logic [ADDR_W-1:0]  r_w_addr;
  logic               r_w_en;
  logic               r_frame_done;
  logic [7:0]         r_frame_count;
  logic               r_line_err;

  logic [7:0]         w_pix;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_wr_ok;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_SYNC;
    else       r_state <= w_state_nxt;
  end

  // Next state; VSYNC takes priority over HREF.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC:   if (VSYNC) w_state_nxt = S_VBLANK;
      S_VBLANK: if (!VSYNC) w_state_nxt = S_FRAME;
      S_FRAME:  if (VSYNC) w_state_nxt = S_VBLANK;
                else if (HREF) w_state_nxt = S_LINE;
      S_LINE:   if (VSYNC) w_state_nxt = S_VBLANK;
                else if (!HREF) w_state_nxt = S_FRAME;
      default:  w_state_nxt = S_SYNC;
    endcase
  end

  // Event decode. The first byte of a line arrives while still in S_FRAME.
  always_comb begin
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    w_line_end    = 1'b0;
    w_byte        = 1'b0;
    case (r_state)
      S_VBLANK: w_frame_start = !VSYNC;
      S_FRAME: begin
        w_frame_end = VSYNC;
        w_byte      = !VSYNC && HREF;
      end
      S_LINE: begin
        w_frame_end = VSYNC;
        w_line_end  = !VSYNC && !HREF;
        w_byte      = !VSYNC && HREF;
      end
      default: ;
    endcase
  end

  // Pixel packing from stored byte0 and the current byte1.
  always_comb begin
    w_pix = r_b0;
    case (r_mode)
      2'd0:    w_pix = {r_b0[7:5], r_b0[2:0], D[4:3]};
      2'd1:    w_pix = {r_b0[3:1], D[7:5], D[3:2]};
      2'd2:    w_pix = {r_b0[7:5], r_b0[7:5], r_b0[7:6]};
      default: w_pix = r_b0;
    endcase
  end

  assign w_addr  = ADDR_W'(r_y) * ADDR_W'(WIDTH) + ADDR_W'(r_x);
  assign w_wr_ok = r_armed && (r_x < XW'(WIDTH)) && (r_y < YW'(HEIGHT));

  // Capture datapath and status outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_x           <= '0;
      r_y           <= '0;
      r_phase       <= 1'b0;
      r_b0          <= '0;
      r_mode        <= '0;
      r_armed       <= 1'b0;
      r_pixel       <= '0;
      r_w_addr      <= '0;
      r_w_en        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_line_err    <= 1'b0;
    end else begin
      r_w_en       <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      if (w_frame_start) begin
        r_mode  <= MODE;
        r_armed <= CAPTURE_EN;
        r_x     <= '0;
        r_y     <= '0;
        r_phase <= 1'b0;
      end else if (w_frame_end) begin
        r_x     <= '0;
        r_y     <= '0;
        r_phase <= 1'b0;
        if (r_armed) begin
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 8'd1;
        end
      end else if (w_line_end) begin
        // A dangling odd byte is dropped by clearing the phase.
        r_phase <= 1'b0;
        r_x     <= '0;
        if (r_x != '0 && r_y != '1) r_y <= r_y + YW'(1);
        if (r_x != XW'(WIDTH)) r_line_err <= 1'b1;
      end else if (w_byte) begin
        if (!r_phase) begin
          r_b0    <= D;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (r_x != '1) r_x <= r_x + XW'(1);
          if (w_wr_ok) begin
            r_pixel  <= w_pix;
            r_w_addr <= w_addr;
            r_w_en   <= 1'b1;
          end
        end
      end
    end
  end

  assign PIXEL_OUT   = r_pixel;
  assign W_ADDR      = r_w_addr;
  assign W_EN        = r_w_en;
  assign FRAME_DONE  = r_frame_done;
  assign FRAME_COUNT = r_frame_count;
  assign LINE_ERR    = r_line_err;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Scoreboard bench for cam_capture_rgb332: a behavioural model predicts every
// RAM write, frame-done and line-error event; the monitor compares on negedge.
module tb_cam_capture_rgb332;

  localparam int W  = 176;
  localparam int H  = 144;
  localparam int AW = 15;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          VSYNC = 1'b0;
  logic          HREF = 1'b0;
  logic [7:0]    D = '0;
  logic [1:0]    MODE = '0;
  logic          CAPTURE_EN = 1'b0;
  logic [7:0]    PIXEL_OUT;
  logic [AW-1:0] W_ADDR;
  logic          W_EN;
  logic          FRAME_DONE;
  logic [7:0]    FRAME_COUNT;
  logic          LINE_ERR;

  cam_capture_rgb332 #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .MODE(MODE), .CAPTURE_EN(CAPTURE_EN), .PIXEL_OUT(PIXEL_OUT),
    .W_ADDR(W_ADDR), .W_EN(W_EN), .FRAME_DONE(FRAME_DONE),
    .FRAME_COUNT(FRAME_COUNT), .LINE_ERR(LINE_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and observed-event counters.
  int        exp_addr_q[$];
  logic [7:0] exp_pix_q[$];
  int wr_seen = 0, done_seen = 0, lerr_seen = 0, last_addr = -1;

  // Reference model state.
  bit        m_synced = 0, m_armed = 0, m_phase = 0;
  logic [1:0] m_mode = '0;
  logic [7:0] m_b0 = '0;
  int        m_x = 0, m_y = 0;
  int        exp_done = 0, exp_lerr = 0, exp_cnt = 0;

  function automatic logic [7:0] fmt(input logic [1:0] m, input logic [7:0] b0, input logic [7:0] b1);
    case (m)
      2'd0:    return {b0[7:5], b0[2:0], b1[4:3]};
      2'd1:    return {b0[3:1], b1[7:5], b1[3:2]};
      2'd2:    return {b0[7:5], b0[7:5], b0[7:6]};
      default: return b0;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (W_EN) begin
      wr_seen++;
      last_addr = int'(W_ADDR);
      if (exp_addr_q.size() == 0) check("unexpected_wen", 32'(W_EN), 32'd0);
      else begin
        check("w_addr", 32'(W_ADDR), 32'(exp_addr_q.pop_front()));
        check("pixel", 32'(PIXEL_OUT), 32'(exp_pix_q.pop_front()));
      end
    end
    if (FRAME_DONE) done_seen++;
    if (LINE_ERR) lerr_seen++;
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic model_byte(input logic [7:0] d);
    if (!m_synced) return;
    if (!m_phase) begin
      m_b0 = d; m_phase = 1;
    end else begin
      m_phase = 0;
      if (m_armed && m_x < W && m_y < H) begin
        exp_addr_q.push_back(m_y * W + m_x);
        exp_pix_q.push_back(fmt(m_mode, m_b0, d));
      end
      m_x++;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d);
    HREF = 1'b1; D = d;
    model_byte(d);
    step();
  endtask

  task automatic line_end();
    HREF = 1'b0;
    if (m_synced) begin
      if (m_x != W) exp_lerr++;
      if (m_x > 0) m_y++;
    end
    m_x = 0; m_phase = 0;
    step(); step();
  endtask

  task automatic drive_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) drive_byte(8'($urandom));
    line_end();
  endtask

  task automatic frame_end();
    HREF = 1'b0; VSYNC = 1'b1;
    if (m_synced && m_armed) begin exp_done++; exp_cnt = (exp_cnt + 1) % 256; end
    m_synced = m_synced; m_x = 0; m_y = 0; m_phase = 0;
    repeat (3) step();
    check("frame_done_cnt", 32'(done_seen), 32'(exp_done));
    check("frame_count", 32'(FRAME_COUNT), 32'(exp_cnt));
    check("line_err_cnt", 32'(lerr_seen), 32'(exp_lerr));
    check("sb_pending", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic frame_start(input logic [1:0] m, input bit cap);
    MODE = m; CAPTURE_EN = cap; VSYNC = 1'b0;
    m_synced = 1; m_mode = m; m_armed = cap; m_x = 0; m_y = 0; m_phase = 0;
    step(); step();
  endtask

  task automatic model_reset();
    m_synced = 0; m_armed = 0; m_mode = '0; m_x = 0; m_y = 0; m_phase = 0; exp_cnt = 0;
  endtask

  int wr0;

  initial begin
    // Reset values.
    repeat (2) step();
    check("rst_pixel", 32'(PIXEL_OUT), 32'd0);
    check("rst_addr", 32'(W_ADDR), 32'd0);
    check("rst_wen", 32'(W_EN), 32'd0);
    check("rst_count", 32'(FRAME_COUNT), 32'd0);
    RESET = 1'b0;
    step();

    // Mid-frame traffic after reset must be ignored until a VSYNC cycle.
    HREF = 1'b1;
    drive_line(40);
    frame_end();
    frame_start(2'd0, 1'b1);
    drive_line(6);
    drive_byte(8'h5A);
    // Asynchronous reset mid-line with HREF high.
    #3 RESET = 1'b1;
    #1;
    model_reset();
    check("arst_pixel", 32'(PIXEL_OUT), 32'd0);
    check("arst_addr", 32'(W_ADDR), 32'd0);
    check("arst_wen", 32'(W_EN), 32'd0);
    check("arst_done", 32'(FRAME_DONE), 32'd0);
    check("arst_lerr", 32'(LINE_ERR), 32'd0);
    step(); step();
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) drive_byte(8'($urandom));
    line_end();
    drive_line(20);
    check("no_wr_unsynced", 32'(exp_addr_q.size()), 32'd0);
    frame_end();

    // First pixel, RGB565: 0xF8,0x1F -> 0xE3 at address 0, strobe one cycle after b1.
    frame_start(2'd0, 1'b1);
    drive_byte(8'hF8);
    drive_byte(8'h1F);
    check("first_wen", 32'(W_EN), 32'd1);
    check("first_pix", 32'(PIXEL_OUT), 32'hE3);
    check("first_addr", 32'(W_ADDR), 32'd0);
    line_end();
    check("first_wen_single", 32'(wr_seen), 32'd4);
    frame_end();

    // Full frame after a fresh reset.
    RESET = 1'b1; step(); RESET = 1'b0; model_reset(); step();
    frame_end();
    frame_start(2'd1, 1'b1);
    wr0 = wr_seen;
    for (int l = 0; l < H; l++) drive_line(2 * W);
    frame_end();
    check("full_writes", 32'(wr_seen - wr0), 32'd25344);
    check("full_last_addr", 32'(last_addr), 32'd25343);
    check("full_count", 32'(FRAME_COUNT), 32'd1);

    // Over-long then short line.
    frame_start(2'd0, 1'b1);
    wr0 = wr_seen;
    drive_line(360);
    drive_line(340);
    check("long_short_writes", 32'(wr_seen - wr0), 32'd346);
    check("long_short_last", 32'(last_addr), 32'd345);
    frame_end();

    // Odd byte count: trailing byte dropped, next line restarts at phase 0.
    frame_start(2'd3, 1'b1);
    drive_line(353);
    drive_line(10);
    check("odd_last", 32'(last_addr), 32'd180);
    frame_end();

    // Unarmed frame, enable raised mid-frame.
    frame_start(2'd0, 1'b0);
    CAPTURE_EN = 1'b1;
    MODE = 2'd2;
    wr0 = wr_seen;
    drive_line(20);
    frame_end();
    check("unarmed_writes", 32'(wr_seen - wr0), 32'd0);

    // Mode change mid-frame takes effect only at the next frame.
    frame_start(2'd0, 1'b1);
    drive_line(10);
    MODE = 2'd2;
    drive_line(10);
    frame_end();
    frame_start(2'd2, 1'b1);
    drive_line(10);
    frame_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
